// File: rtl/sample_capture_pkg.sv
// Shared types and defaults for the trigger-controlled sample capture buffer.
// DATA_W default matches the decimator output width.
package sample_capture_pkg;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } cap_state_e;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/sample_capture_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
// Storage is deliberately not reset so it maps onto block RAM.
module sample_capture_ram
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Same-address read during a write returns the previous contents.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_capture.sv
// Trigger-controlled circular capture of decimated samples: freezes DEPTH samples
// around a level-crossing or forced trigger, with programmable pre-trigger depth.
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              arm,
  input  logic [ADDR_W-1:0] pre_trig,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_rising,
  input  logic              force_trig,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [2:0]        dbg_state
);

  cap_state_e        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] post_cnt;
  logic [DATA_W-1:0] level_q;
  logic [DATA_W-1:0] prev;
  logic              rising_q;
  logic              prev_valid;
  logic              force_q;

  logic              capturing;
  logic              wr_en;
  logic              rise_hit;
  logic              fall_hit;
  logic              trig_hit;
  logic [ADDR_W-1:0] post_init;

  // A strobe coinciding with arm belongs to the old capture and is dropped.
  assign capturing = (state == ST_PRE) || (state == ST_ARMED) || (state == ST_POST);
  assign wr_en     = sample_valid && !arm && capturing;

  assign rise_hit  = prev_valid && rising_q  && (prev <  level_q) && (level_q <= sample_data);
  assign fall_hit  = prev_valid && !rising_q && (prev >= level_q) && (level_q >  sample_data);
  assign trig_hit  = force_q || rise_hit || fall_hit;

  // DEPTH-1-pre_trig, computed modulo DEPTH.
  assign post_init = {ADDR_W{1'b1}} - pre_q;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      pre_q      <= '0;
      post_cnt   <= '0;
      level_q    <= '0;
      prev       <= '0;
      rising_q   <= 1'b0;
      prev_valid <= 1'b0;
      force_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      start_addr <= '0;
    end else if (arm) begin
      wr_ptr     <= '0;
      prev_valid <= 1'b0;
      force_q    <= 1'b0;
      pre_q      <= pre_trig;
      level_q    <= trig_level;
      rising_q   <= trig_rising;
      busy       <= 1'b1;
      done       <= 1'b0;
      state      <= (pre_trig == '0) ? ST_ARMED : ST_PRE;
    end else begin
      if (force_trig && ((state == ST_PRE) || (state == ST_ARMED)))
        force_q <= 1'b1;

      if (wr_en) begin
        prev       <= sample_data;
        prev_valid <= 1'b1;
        wr_ptr     <= wr_ptr + 1'b1;
      end

      if (sample_valid) begin
        case (state)
          ST_PRE: begin
            if (wr_ptr == pre_q - 1'b1) state <= ST_ARMED;
          end
          ST_ARMED: begin
            if (trig_hit) begin
              start_addr <= wr_ptr - pre_q;
              post_cnt   <= post_init;
              force_q    <= 1'b0;
              if (post_init == '0) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= ST_POST;
              end
            end
          end
          ST_POST: begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == {{(ADDR_W-1){1'b0}}, 1'b1}) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  sample_capture_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .rstn   (rstn),
    .we     (wr_en),
    .wr_addr(wr_ptr),
    .wr_data(sample_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_sample_capture.sv
// Directed bench for sample_capture with DEPTH=16 and a sample strobe every 11 cycles.
module tb_sample_capture;

  localparam int DW = 10;
  localparam int AW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_POST  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          arm;
  logic [AW-1:0] pre_trig;
  logic [DW-1:0] trig_level;
  logic          trig_rising;
  logic          force_trig;
  logic          busy;
  logic          done;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [2:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  sample_capture #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .arm         (arm),
    .pre_trig    (pre_trig),
    .trig_level  (trig_level),
    .trig_rising (trig_rising),
    .force_trig  (force_trig),
    .busy        (busy),
    .done        (done),
    .start_addr  (start_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic do_arm(input logic [AW-1:0] pt, input logic [DW-1:0] lvl, input logic rise,
                        input logic with_v, input logic [DW-1:0] vd);
    @(negedge clk);
    arm = 1'b1; pre_trig = pt; trig_level = lvl; trig_rising = rise;
    sample_valid = with_v; sample_data = vd;
    @(negedge clk);
    arm = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    @(negedge clk);
    sample_valid = 1'b1; sample_data = d;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic pulse_force();
    @(negedge clk);
    force_trig = 1'b1;
    @(negedge clk);
    force_trig = 1'b0;
  endtask

  // scoreboard: pops one expected word per read
  task automatic read_check(input logic [AW-1:0] a, input string tag);
    logic [DW-1:0] e;
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, rd_data, e);
  endtask

  initial begin
    rstn = 1'b0; sample_valid = 1'b0; sample_data = '0; arm = 1'b0;
    pre_trig = '0; trig_level = '0; trig_rising = 1'b0; force_trig = 1'b0; rd_addr = '0;

    // reset
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", start_addr, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_state", dbg_state, S_IDLE);
    rstn = 1'b1;
    send(10'd123);
    check("idle_state", dbg_state, S_IDLE);
    check("idle_busy", busy, 0);

    // rising trigger, pre_trig=4, level 55
    do_arm(4'd4, 10'd55, 1'b1, 1'b0, '0);
    check("r_busy", busy, 1);
    check("r_state_pre", dbg_state, S_PRE);
    for (int k = 0; k < 18; k++) begin
      send(DW'(k * 10));
      if (k == 2)  check("r_pre_k2", dbg_state, S_PRE);
      if (k == 3)  check("r_armed_k3", dbg_state, S_ARMED);
      if (k == 5)  check("r_armed_k5", dbg_state, S_ARMED);
      if (k == 6)  check("r_post_k6", dbg_state, S_POST);
      if (k == 6)  check("r_start", start_addr, 2);
      if (k == 16) check("r_done_k16", done, 0);
    end
    check("r_done", done, 1);
    check("r_busy_end", busy, 0);
    check("r_state_done", dbg_state, S_DONE);
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'((i + 2) * 10));
    for (int i = 0; i < 16; i++) read_check(AW'(i + 2), "r_mem");

    // force trigger with pre_trig=0
    do_arm(4'd0, 10'd55, 1'b1, 1'b0, '0);
    check("f_state_armed", dbg_state, S_ARMED);
    check("f_done_clr", done, 0);
    @(negedge clk);
    pulse_force();
    for (int i = 0; i < 16; i++) begin
      send(DW'(100 + i));
      if (i == 0)  check("f_post", dbg_state, S_POST);
      if (i == 0)  check("f_start", start_addr, 0);
      if (i == 14) check("f_done_i14", done, 0);
    end
    check("f_done", done, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'(100 + i));
    for (int i = 0; i < 16; i++) read_check(AW'(i), "f_mem");

    // falling trigger, level 500
    do_arm(4'd0, 10'd500, 1'b0, 1'b0, '0);
    send(10'd300);
    check("fa_300", dbg_state, S_ARMED);
    send(10'd600);
    check("fa_600", dbg_state, S_ARMED);
    send(10'd400);
    check("fa_400", dbg_state, S_POST);
    check("fa_start", start_addr, 2);

    // re-arm during POST
    do_arm(4'd2, 10'd55, 1'b1, 1'b0, '0);
    check("ra_busy", busy, 1);
    check("ra_done", done, 0);
    check("ra_state", dbg_state, S_PRE);
    for (int k = 0; k < 20; k++) begin
      send(DW'(k * 10));
      if (k == 1)  check("ra_armed", dbg_state, S_ARMED);
      if (k == 6)  check("ra_post", dbg_state, S_POST);
      if (k == 6)  check("ra_start", start_addr, 4);
      if (k == 18) check("ra_done_k18", done, 0);
    end
    check("ra_done_end", done, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back(DW'((i + 4) * 10));
    for (int i = 0; i < 16; i++) read_check(AW'(i + 4), "ra_mem");

    // crossing during PRE is ignored
    do_arm(4'd3, 10'd55, 1'b1, 1'b0, '0);
    send(10'd0);
    send(10'd100);
    check("p_cross_pre", dbg_state, S_PRE);
    send(10'd100);
    check("p_armed", dbg_state, S_ARMED);
    send(10'd200);
    check("p_no_trig", dbg_state, S_ARMED);

    // arm with a same-cycle strobe: that sample is dropped
    do_arm(4'd0, 10'd1000, 1'b1, 1'b1, 10'd999);
    pulse_force();
    @(negedge clk);
    rd_addr = '0; sample_valid = 1'b1; sample_data = 10'd7;
    @(negedge clk);
    sample_valid = 1'b0;
    check("s_rd_old", rd_data, 0);
    @(negedge clk);
    check("s_rd_new", rd_data, 7);
    check("s_start", start_addr, 0);
    repeat (8) @(negedge clk);
    for (int i = 1; i < 16; i++) send(DW'(7 + i));
    check("s_done", done, 1);
    exp_q.push_back(10'd7);
    exp_q.push_back(10'd8);
    exp_q.push_back(10'd22);
    read_check(4'd0, "s_mem0");
    read_check(4'd1, "s_mem1");
    read_check(4'd15, "s_mem15");

    // asynchronous reset mid-capture
    do_arm(4'd0, 10'd55, 1'b1, 1'b0, '0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 check("ar_state", dbg_state, S_IDLE);
    check("ar_busy", busy, 0);
    @(negedge clk);
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
# sample_capture

Trigger-controlled capture buffer that sits directly downstream of the decimator. It takes each decimated 10-bit sample and its one-cycle strobe, and writes the samples into a circular RAM with a programmable pre-trigger depth. When the trigger condition is met it freezes exactly DEPTH samples around the trigger point. A host reads the frozen window through a synchronous read port.

## Interface
- DATA_W, default 10, sample width (unsigned, offset-binary).
- ADDR_W, default 8, buffer address width; DEPTH = 2**ADDR_W.
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  one-cycle strobe from the decimator's new_sample_clk.
- sample_data  in  DATA_W  decimated sample; valid only when sample_valid=1.
- arm  in  1  pulse that starts a new capture.
- pre_trig  in  ADDR_W  number of samples kept before the trigger sample; sampled when arm=1.
- trig_level  in  DATA_W  level threshold.
- trig_rising  in  1  1 selects rising crossing, 0 selects falling; level and edge are sampled when arm=1.
- force_trig  in  1  pulse that triggers on the next eligible sample.
- busy  out  1  high in PRE, ARMED and POST.
- done  out  1  high in DONE.
- start_addr  out  ADDR_W  buffer address of the oldest captured sample.
- rd_addr  in  ADDR_W  host read address.
- rd_data  out  DATA_W  registered read data.

## Operation
- States: IDLE, PRE, ARMED, POST, DONE.
- Only the sample_valid cycles advance the FSM or write the RAM.
- arm=1 in any state does the following:
  - clears wr_ptr, the prev-valid flag and the force latch;
  - latches pre_trig, trig_level and trig_rising;
  - moves to PRE, or to ARMED if pre_trig=0.
  - A sample_valid in the same cycle as arm is discarded.
- PRE: each sample is written at wr_ptr and wr_ptr increments modulo DEPTH. When the written sample is the pre_trig-th one, move to ARMED. Level triggers are ignored in PRE, but prev is still updated.
- ARMED: each sample is written at wr_ptr. A trigger occurs on that sample when either:
  - the force latch is set, or
  - the prev-valid flag is set and the edge matches: rising means prev < level ≤ cur; falling means prev ≥ level > cur (unsigned comparison).
- On a trigger:
  - trig_addr ← wr_ptr;
  - post_cnt ← DEPTH−1−pre_trig;
  - go to DONE if post_cnt=0, otherwise to POST.
  - Without a trigger the ring keeps overwriting the oldest samples.
- POST: each sample is written and decrements post_cnt. The sample that brings post_cnt to 0 is the last one written; the FSM then goes to DONE.
- Each capture contains exactly DEPTH samples.
- start_addr = trig_addr − pre_trig (mod DEPTH); it is updated in the trigger cycle.
- force_trig asserted in PRE or ARMED sets the latch. It is ignored in IDLE, POST and DONE.
- prev is updated on every written sample. prev-valid is set after the first written sample following arm.
- DONE: no writes. The state holds until the next arm.
- Read port: rd_data ← mem[rd_addr] every cycle. A read of the address being written in the same cycle returns the old data.
- The memory is not reset.

## Timing
- Reset values: state IDLE, busy 0, done 0, start_addr 0, rd_data 0. Internal registers reset to 0: wr_ptr, post_cnt, prev, prev-valid, force latch.
- busy rises in the cycle after arm.
- done rises in the cycle after the last POST write, or in the cycle after the trigger write when post_cnt=0.
- Read latency is 1 cycle.
- Reset mid-capture returns the block to IDLE immediately. RAM contents are undefined afterwards.
- There is no minimum gap between sample_valid pulses; back-to-back strobes are legal.

## Structure
- Shared package holds:
  - the state enum;
  - the DATA_W=10 default, matching the decimator output;
  - a helper for DEPTH derived from ADDR_W.
- One sub-module: sample_capture_ram, a simple dual-port RAM with one write port and one registered read port, inferable as block RAM.
- The FSM, trigger compare and pointers live in the top level.

## Test plan
All scenarios use ADDR_W=4 (DEPTH=16) and sample_valid every 11 cycles.
- Reset: all outputs 0. sample_valid with no arm leaves the state IDLE and busy 0.
- Rising trigger:
  - Stimulus: arm with pre_trig=4, level=55, rising; ramp sample k=k·10 for k=0..17.
  - Required response: trigger at k=6 (addr 6); start_addr=2; done after k=17.
  - Reading addresses 2..15, 0..1 returns 20,30,…,170.
- Force trigger:
  - Stimulus: pre_trig=0; force_trig in the arm+3 cycle; samples 100,101,…
  - Required response: trigger on the first sample (addr 0); start_addr=0; done after 16 samples; mem[i]=100+i.
- Falling trigger:
  - Stimulus: level=500, falling; first sample 300, then 600 then 400.
  - Required response: no trigger on 300; trigger on 400.
  - Also: stimulus with pre_trig=3 and a crossing at the second sample → no trigger while in PRE.
- Re-arm mid-POST: arm during POST → busy stays high, wr_ptr restarts at 0, done stays 0, and the new capture completes correctly.
- Same-cycle arm and sample_valid: that sample is not written. The next sample lands at addr 0.
